// File: rtl/intc_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
package intc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int unsigned MAX_IRQ      = 32;
  localparam logic [31:0] DEF_VEC_BASE = 32'h10;

  // Index of the highest-priority (lowest-numbered) set bit; 0 when none set.
  function automatic logic [4:0] lowest_set(input logic [MAX_IRQ-1:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Request/config inputs and CU-facing outputs of the interrupt controller.
interface int_ctrl_if #(
  parameter int unsigned NUM_IRQ = 8
);
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_en;
  logic [NUM_IRQ-1:0] irq_edge;
  logic               imask;
  logic               int_ack;
  logic               eoi;
  logic               hwint;
  logic [31:0]        vector;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] in_service;

  modport master (
    output irq, irq_en, irq_edge, imask, int_ack, eoi,
    input  hwint, vector, pending, in_service
  );

  modport slave (
    input  irq, irq_en, irq_edge, imask, int_ack, eoi,
    output hwint, vector, pending, in_service
  );
endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: index of the lowest set bit plus a valid flag.
module prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]     req,
  output logic             valid,
  output logic [((W > 1) ? $clog2(W) : 1)-1:0] idx
);
  localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;

  always_comb begin
    valid = |req;
    idx   = IDX_W'(lowest_set(MAX_IRQ'(req)));
  end
endmodule

// File: rtl/int_ctrl.sv
// Vectored, nesting, fixed-priority interrupt controller feeding the CU hwint line.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = 8,
  parameter logic [31:0] VEC_BASE = DEF_VEC_BASE
) (
  input logic       clk,
  input logic       rst,
  int_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_t             state_q, state_d;
  logic               hwint_q, hwint_d;
  logic [31:0]        vector_q, vector_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic [NUM_IRQ-1:0] irq_q, pending_q, pending_d, in_service_q, in_service_d;

  logic               cand_valid, is_valid, preempt_c, ack_fire_c;
  logic [IDX_W-1:0]   cand_idx, is_idx;
  logic [NUM_IRQ-1:0] eligible_c, ack_sel_c, eoi_clr_c;

  assign eligible_c = pending_q & bus.irq_en;

  prio_enc #(.W(NUM_IRQ)) u_cand_enc (
    .req   (eligible_c),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  prio_enc #(.W(NUM_IRQ)) u_is_enc (
    .req   (in_service_q),
    .valid (is_valid),
    .idx   (is_idx)
  );

  // Nesting only when strictly higher priority than the deepest active handler.
  assign preempt_c = !is_valid || (cand_idx < is_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    hwint_d    = hwint_q;
    vector_d   = vector_q;
    cur_idx_d  = cur_idx_q;
    ack_fire_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.imask && cand_valid && preempt_c) begin
          state_d   = REQ;
          cur_idx_d = cand_idx;
          vector_d  = VEC_BASE + 32'(cand_idx);
          hwint_d   = 1'b1;
        end
      end
      REQ: begin
        // A CU ack wins over a simultaneous imask drop: the PC is already loaded.
        if (bus.int_ack) begin
          ack_fire_c = 1'b1;
          hwint_d    = 1'b0;
          state_d    = IDLE;
        end else if (!bus.imask) begin
          hwint_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // EOI works on the pre-ack in_service image; the ack bit is OR-ed in after.
  always_comb begin
    ack_sel_c    = ack_fire_c ? (NUM_IRQ'(1) << cur_idx_q) : '0;
    eoi_clr_c    = (bus.eoi && is_valid) ? (NUM_IRQ'(1) << is_idx) : '0;
    in_service_d = (in_service_q & ~eoi_clr_c) | ack_sel_c;
    pending_d    = (bus.irq_edge & ((pending_q & ~ack_sel_c) | (bus.irq & ~irq_q)))
                 | (~bus.irq_edge & bus.irq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwint_q      <= 1'b0;
      vector_q     <= '0;
      cur_idx_q    <= '0;
      irq_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      hwint_q      <= hwint_d;
      vector_q     <= vector_d;
      cur_idx_q    <= cur_idx_d;
      irq_q        <= bus.irq;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign bus.hwint      = hwint_q;
  assign bus.vector     = vector_q;
  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl (NUM_IRQ=8, VEC_BASE=0x10, channel 6 level).
module tb_int_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  int_ctrl_if #(.NUM_IRQ(8)) bus ();

  int_ctrl #(.NUM_IRQ(8), .VEC_BASE(32'h10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
  endtask

  initial begin
    bus.irq      = '0;
    bus.irq_en   = 8'hFF;
    bus.irq_edge = 8'hBF;
    bus.imask    = 1'b1;
    bus.int_ack  = 1'b0;
    bus.eoi      = 1'b0;
    #12 rst = 1'b0;
    step();
    check("rst_hwint", 32'(bus.hwint), 32'h0);
    check("rst_vector", bus.vector, 32'h0);
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_in_service", 32'(bus.in_service), 32'h0);

    // Single edge channel 3
    bus.irq = 8'h08; step();
    check("e3_pending", 32'(bus.pending), 32'h08);
    check("e3_hwint_early", 32'(bus.hwint), 32'h0);
    bus.irq = 8'h00; step();
    check("e3_hwint", 32'(bus.hwint), 32'h1);
    check("e3_vector", bus.vector, 32'h13);
    pulse_ack();
    check("e3_ack_hwint", 32'(bus.hwint), 32'h0);
    check("e3_ack_is", 32'(bus.in_service), 32'h08);
    check("e3_ack_pending", 32'(bus.pending), 32'h00);
    pulse_eoi();
    check("e3_eoi_is", 32'(bus.in_service), 32'h00);

    // Channels 5 and 2 together; 5 must wait for EOI of 2
    bus.irq = 8'h24; step();
    bus.irq = 8'h00; step();
    check("p25_vector", bus.vector, 32'h12);
    check("p25_hwint", 32'(bus.hwint), 32'h1);
    pulse_ack();
    check("p25_ack_is", 32'(bus.in_service), 32'h04);
    check("p25_ack_pending", 32'(bus.pending), 32'h20);
    step(2);
    check("p25_blocked", 32'(bus.hwint), 32'h0);
    pulse_eoi();
    check("p25_eoi_is", 32'(bus.in_service), 32'h00);
    step();
    check("p25_hwint5", 32'(bus.hwint), 32'h1);
    check("p25_vector5", bus.vector, 32'h15);
    pulse_ack();
    check("p25_ack5_is", 32'(bus.in_service), 32'h20);
    pulse_eoi();

    // Nesting: channel 1 preempts in-service channel 4
    bus.irq = 8'h10; step();
    bus.irq = 8'h00; step();
    check("n4_vector", bus.vector, 32'h14);
    pulse_ack();
    check("n4_is", 32'(bus.in_service), 32'h10);
    bus.irq = 8'h02; step();
    bus.irq = 8'h00; step();
    check("n1_hwint", 32'(bus.hwint), 32'h1);
    check("n1_vector", bus.vector, 32'h11);
    pulse_ack();
    check("n1_is", 32'(bus.in_service), 32'h12);
    pulse_eoi();
    check("n1_eoi_is", 32'(bus.in_service), 32'h10);
    pulse_eoi();
    check("n4_eoi_is", 32'(bus.in_service), 32'h00);

    // Level channel 6 held through ack and EOI
    bus.irq = 8'h40; step();
    check("l6_pending", 32'(bus.pending), 32'h40);
    step();
    check("l6_vector", bus.vector, 32'h16);
    pulse_ack();
    check("l6_ack_pending", 32'(bus.pending), 32'h40);
    check("l6_ack_is", 32'(bus.in_service), 32'h40);
    step();
    check("l6_no_self_nest", 32'(bus.hwint), 32'h0);
    pulse_eoi();
    step();
    check("l6_rearm_hwint", 32'(bus.hwint), 32'h1);
    check("l6_rearm_vector", bus.vector, 32'h16);
    pulse_ack();
    bus.irq = 8'h00; step();
    check("l6_drop_pending", 32'(bus.pending), 32'h00);
    pulse_eoi();
    step();
    check("l6_idle_hwint", 32'(bus.hwint), 32'h0);
    check("l6_idle_is", 32'(bus.in_service), 32'h00);

    // Global mask holds off channel 0
    bus.imask = 1'b0;
    bus.irq = 8'h01; step();
    bus.irq = 8'h00; step(2);
    check("m0_hwint", 32'(bus.hwint), 32'h0);
    check("m0_pending", 32'(bus.pending), 32'h01);
    bus.imask = 1'b1; step();
    check("m0_unmask_hwint", 32'(bus.hwint), 32'h1);
    check("m0_unmask_vector", bus.vector, 32'h10);

    // Asynchronous reset while in REQ
    rst = 1'b1; #2;
    check("ar_hwint", 32'(bus.hwint), 32'h0);
    check("ar_pending", 32'(bus.pending), 32'h0);
    check("ar_is", 32'(bus.in_service), 32'h0);
    check("ar_vector", bus.vector, 32'h0);
    step();
    rst = 1'b0;
    pulse_ack();
    check("ar_ack_hwint", 32'(bus.hwint), 32'h0);
    check("ar_ack_is", 32'(bus.in_service), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
